// File: rtl/neuron_mac_pkg.sv
// Shared types and Q32.32 constants for the perceptron datapath and later layer blocks.
package neuron_mac_pkg;

   typedef enum logic [1:0] {
      ACT_STEP    = 2'd0,
      ACT_SIGMOID = 2'd1,
      ACT_TANH    = 2'd2,
      ACT_RELU    = 2'd3
   } act_func_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_ACT,
      ST_OUT
   } state_e;

   localparam int          Q_WIDTH = 64;
   localparam int          Q_FRAC  = 32;
   localparam logic [63:0] Q_ONE   = 64'h0000_0001_0000_0000;
   localparam logic [63:0] Q_MAX   = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] Q_MIN   = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/neuron_mac_fx_mul_sat.sv
// Combinational fixed-point multiply: full product, arithmetic shift by FRAC,
// then reduce to WIDTH bits by clamping or by dropping the upper bits.
module fx_mul_sat #(
   parameter int WIDTH    = 64,
   parameter int FRAC     = 32,
   parameter int SATURATE = 1
) (
   input  logic signed [WIDTH-1:0] x_i,
   input  logic signed [WIDTH-1:0] w_i,
   output logic signed [WIDTH-1:0] p_o,
   output logic                    ov_o
);

   localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

   logic signed [2*WIDTH-1:0] prod;
   logic signed [2*WIDTH-1:0] shr;
   logic                      fits;

   assign prod = x_i * w_i;
   assign shr  = prod >>> FRAC;
   // Result fits when every bit above the kept sign bit matches it.
   assign fits = (&shr[2*WIDTH-1:WIDTH-1]) | ~(|shr[2*WIDTH-1:WIDTH-1]);

   always_comb begin
      p_o  = shr[WIDTH-1:0];
      ov_o = 1'b0;
      if (SATURATE != 0 && !fits) begin
         ov_o = 1'b1;
         p_o  = shr[2*WIDTH-1] ? MINV : MAXV;
      end
   end

endmodule

// File: rtl/neuron_mac.sv
// Perceptron MAC: bias + sum(x*w) over a beat stream, activation, and one
// registered result per evaluation on a valid/ready output.
module neuron_mac
   import neuron_mac_pkg::*;
#(
   parameter int WIDTH     = Q_WIDTH,
   parameter int FRAC      = Q_FRAC,
   parameter int MAX_BEATS = 256,
   parameter int SATURATE  = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_x,
   input  logic signed [WIDTH-1:0] in_w,
   input  logic                    in_last,
   input  logic signed [WIDTH-1:0] bias,
   input  logic [1:0]              act_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_y,
   output logic                    out_sat,
   output logic                    out_err
);

   if (FRAC >= WIDTH - 1) begin : g_bad_frac
      $error("neuron_mac: FRAC must be less than WIDTH-1");
   end

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic signed [WIDTH-1:0] MAXV    = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MINV    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
   localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;
   localparam logic signed [WIDTH:0]   ONE_X   = $signed({1'b0, ONE});
   localparam logic signed [WIDTH:0]   HALF_X  = $signed({1'b0, ONE >> 1});

   state_e                  state_q;
   act_func_e               act_q;
   logic signed [WIDTH-1:0] acc_q, acc_d, out_y_q, act_y;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    sat_q, err_q, in_ready_q, out_valid_q, out_sat_q, out_err_q;

   logic signed [WIDTH-1:0] p, base;
   logic                    mul_ov, add_ov, step_sat, hs;
   logic [WIDTH:0]          sum;
   logic signed [WIDTH:0]   acc_x, sig;

   fx_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SATURATE(SATURATE)) u_mul (
      .x_i  (in_x),
      .w_i  (in_w),
      .p_o  (p),
      .ov_o (mul_ov)
   );

   // The first beat folds the bias in place of the running sum.
   assign base     = (state_q == ST_IDLE) ? bias : acc_q;
   assign sum      = {base[WIDTH-1], base} + {p[WIDTH-1], p};
   assign add_ov   = sum[WIDTH] ^ sum[WIDTH-1];
   assign acc_d    = (SATURATE != 0 && add_ov) ? (sum[WIDTH] ? MINV : MAXV) : sum[WIDTH-1:0];
   assign step_sat = (SATURATE != 0) && (mul_ov || add_ov);
   assign cnt_d    = cnt_q + 1'b1;
   assign hs       = in_valid && in_ready_q;

   assign acc_x = $signed({acc_q[WIDTH-1], acc_q});
   assign sig   = (acc_x >>> 2) + HALF_X;

   always_comb begin
      act_y = '0;
      unique case (act_q)
         ACT_STEP:    act_y = acc_q[WIDTH-1] ? '0 : ONE;
         ACT_SIGMOID: begin
            if (sig[WIDTH])       act_y = '0;
            else if (sig > ONE_X) act_y = ONE;
            else                  act_y = sig[WIDTH-1:0];
         end
         ACT_TANH: begin
            if (acc_q > ONE)          act_y = ONE;
            else if (acc_q < NEG_ONE) act_y = NEG_ONE;
            else                      act_y = acc_q;
         end
         ACT_RELU:    act_y = acc_q[WIDTH-1] ? '0 : acc_q;
         default:     act_y = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         act_q       <= ACT_STEP;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_sat_q   <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (hs) begin
               acc_q <= acc_d;
               act_q <= act_func_e'(act_sel);
               cnt_q <= {{(CW-1){1'b0}}, 1'b1};
               sat_q <= step_sat;
               if (in_last || MAX_BEATS == 1) begin
                  state_q    <= ST_ACT;
                  in_ready_q <= 1'b0;
                  err_q      <= ~in_last;
               end else begin
                  state_q <= ST_ACCUM;
               end
            end
            ST_ACCUM: if (hs) begin
               acc_q <= acc_d;
               cnt_q <= cnt_d;
               sat_q <= sat_q | step_sat;
               // in_last wins over the beat limit on the same beat.
               if (in_last) begin
                  state_q    <= ST_ACT;
                  in_ready_q <= 1'b0;
               end else if (cnt_d == CW'(MAX_BEATS)) begin
                  state_q    <= ST_ACT;
                  in_ready_q <= 1'b0;
                  err_q      <= 1'b1;
               end
            end
            ST_ACT: begin
               out_y_q     <= act_y;
               out_sat_q   <= sat_q;
               out_err_q   <= err_q;
               out_valid_q <= 1'b1;
               state_q     <= ST_OUT;
            end
            ST_OUT: if (out_ready) begin
               out_valid_q <= 1'b0;
               sat_q       <= 1'b0;
               err_q       <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_sat   = out_sat_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: three instances (default, wrapping, MAX_BEATS=4)
// checked against an arithmetic reference model.
module tb_neuron_mac;

   localparam logic [63:0] ONE64  = 64'h0000_0001_0000_0000;
   localparam logic [63:0] NONE64 = 64'hFFFF_FFFF_0000_0000;
   localparam logic [63:0] QMAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] QMIN64 = 64'h8000_0000_0000_0000;
   localparam logic signed [127:0] QMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
   localparam logic signed [127:0] QMIN = -QMAX - 128'sd1;
   localparam logic signed [127:0] ONE  = 128'sh1_0000_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [2:0]       in_valid, in_last, out_ready;
   logic [2:0][63:0] in_x, in_w, bias;
   logic [2:0][1:0]  act_sel;
   wire  [2:0]       in_ready, out_valid, out_sat, out_err;
   wire  [2:0][63:0] out_y;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neuron_mac #(.WIDTH(64), .FRAC(32), .MAX_BEATS(256), .SATURATE(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_x(in_x[0]), .in_w(in_w[0]), .in_last(in_last[0]), .bias(bias[0]),
      .act_sel(act_sel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_y(out_y[0]), .out_sat(out_sat[0]), .out_err(out_err[0]));

   neuron_mac #(.WIDTH(64), .FRAC(32), .MAX_BEATS(256), .SATURATE(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_x(in_x[1]), .in_w(in_w[1]), .in_last(in_last[1]), .bias(bias[1]),
      .act_sel(act_sel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_y(out_y[1]), .out_sat(out_sat[1]), .out_err(out_err[1]));

   neuron_mac #(.WIDTH(64), .FRAC(32), .MAX_BEATS(4), .SATURATE(1)) u_max4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_x(in_x[2]), .in_w(in_w[2]), .in_last(in_last[2]), .bias(bias[2]),
      .act_sel(act_sel[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
      .out_y(out_y[2]), .out_sat(out_sat[2]), .out_err(out_err[2]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic signed [127:0] sx(input logic [63:0] v);
      logic signed [127:0] r;
      r = $signed(v);
      return r;
   endfunction

   // Reduce an exact value to 64 bits: clamp (flagging) or keep the low bits.
   function automatic logic [63:0] reduce(input logic signed [127:0] v, input bit sat, inout bit fl);
      if (sat && v > QMAX) begin fl = 1'b1; return QMAX64; end
      if (sat && v < QMIN) begin fl = 1'b1; return QMIN64; end
      return v[63:0];
   endfunction

   task automatic ref_eval(input int n, input logic [63:0] xs[8], input logic [63:0] ws[8],
                           input logic [63:0] b, input logic [1:0] act, input bit sat,
                           output logic [63:0] y, output bit fl);
      logic [63:0] acc, p;
      logic signed [127:0] a, s;
      fl  = 1'b0;
      acc = b;
      for (int i = 0; i < n; i++) begin
         p   = reduce((sx(xs[i]) * sx(ws[i])) >>> 32, sat, fl);
         acc = reduce(sx(acc) + sx(p), sat, fl);
      end
      a = sx(acc);
      case (act)
         2'd0: y = (a >= 0) ? ONE64 : 64'd0;
         2'd1: begin
            s = (a >>> 2) + ONE / 2;
            if (s < 0) y = 64'd0;
            else if (s > ONE) y = ONE64;
            else y = s[63:0];
         end
         2'd2: y = (a > ONE) ? ONE64 : (a < -ONE) ? NONE64 : acc;
         default: y = (a < 0) ? 64'd0 : acc;
      endcase
   endtask

   function automatic logic [63:0] rnd_val();
      logic [63:0] r;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: return r;
         1: return QMAX64;
         2: return QMIN64;
         3: return $signed(r) >>> 24;
         default: return $signed(r) >>> 30;
      endcase
   endfunction

   task automatic wait_ready(input int d);
      int g = 0;
      while (!in_ready[d] && g < 50) begin tick(); g++; end
      if (!in_ready[d]) chk("in_ready_timeout", {63'd0, in_ready[d]}, 64'd1);
   endtask

   task automatic wait_out(input int d);
      int g = 0;
      while (!out_valid[d] && g < 50) begin tick(); g++; end
      chk("out_valid_timeout", {63'd0, out_valid[d]}, 64'd1);
   endtask

   // Drive n beats (last on beat n), wait for the result and check it against the model.
   task automatic send_eval(input int d, input int n, input logic [63:0] xs[8], input logic [63:0] ws[8],
                            input logic [63:0] b, input logic [1:0] act, input string tag);
      logic [63:0] ey;
      bit          es;
      ref_eval(n, xs, ws, b, act, (d != 1), ey, es);
      bias[d]    = b;
      act_sel[d] = act;
      for (int i = 0; i < n; i++) begin
         in_x[d] = xs[i]; in_w[d] = ws[i];
         in_last[d] = (i == n - 1); in_valid[d] = 1'b1;
         wait_ready(d);
         tick();
      end
      in_valid[d] = 1'b0; in_last[d] = 1'b0;
      wait_out(d);
      chk({tag, "_y"}, out_y[d], ey);
      chk({tag, "_sat"}, {63'd0, out_sat[d]}, {63'd0, es});
      chk({tag, "_err"}, {63'd0, out_err[d]}, 64'd0);
   endtask

   task automatic release_out(input int d, input string tag);
      out_ready[d] = 1'b1;
      tick();
      out_ready[d] = 1'b0;
      chk({tag, "_rel_valid"}, {63'd0, out_valid[d]}, 64'd0);
      chk({tag, "_rel_ready"}, {63'd0, in_ready[d]}, 64'd1);
   endtask

   initial begin
      logic [63:0] xs[8], ws[8];
      logic [63:0] ey, y0;
      bit          es;
      int          acc_n, n, d;
      logic [1:0]  acts[4];
      logic [63:0] t1_exp[4];

      in_valid = '0; in_last = '0; out_ready = '0;
      in_x = '0; in_w = '0; bias = '0; act_sel = '0;
      for (int i = 0; i < 8; i++) begin xs[i] = '0; ws[i] = '0; end

      // Reset values
      #12;
      for (int k = 0; k < 3; k++) begin
         chk("rst_in_ready", {63'd0, in_ready[k]}, 64'd1);
         chk("rst_out_valid", {63'd0, out_valid[k]}, 64'd0);
         chk("rst_out_y", out_y[k], 64'd0);
         chk("rst_out_sat", {63'd0, out_sat[k]}, 64'd0);
         chk("rst_out_err", {63'd0, out_err[k]}, 64'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Two beats summing to -2.0 under every activation
      acts   = '{2'd3, 2'd2, 2'd1, 2'd0};
      t1_exp = '{64'd0, NONE64, 64'd0, 64'd0};
      xs[0] = 64'h2_0000_0000; ws[0] = 64'h0_8000_0000;
      xs[1] = 64'h3_0000_0000; ws[1] = NONE64;
      for (int k = 0; k < 4; k++) begin
         send_eval(0, 2, xs, ws, 64'd0, acts[k], "t1");
         chk("t1_const", out_y[0], t1_exp[k]);
         release_out(0, "t1");
      end

      // Single-beat sigmoid and output latency
      bias[0] = 64'h0_8000_0000; act_sel[0] = 2'd1;
      in_x[0] = ONE64; in_w[0] = ONE64; in_last[0] = 1'b1; in_valid[0] = 1'b1;
      wait_ready(0);
      tick();
      in_valid[0] = 1'b0; in_last[0] = 1'b0;
      chk("t2_valid_k", {63'd0, out_valid[0]}, 64'd0);
      tick();
      chk("t2_valid_k1", {63'd0, out_valid[0]}, 64'd1);
      chk("t2_y", out_y[0], 64'h0000_0000_E000_0000);
      chk("t2_sat", {63'd0, out_sat[0]}, 64'd0);
      chk("t2_err", {63'd0, out_err[0]}, 64'd0);
      release_out(0, "t2");

      // Product overflow: clamp vs wrap
      xs[0] = QMAX64; ws[0] = QMAX64;
      send_eval(0, 1, xs, ws, 64'd0, 2'd3, "t3s");
      chk("t3s_const_y", out_y[0], QMAX64);
      chk("t3s_const_sat", {63'd0, out_sat[0]}, 64'd1);
      release_out(0, "t3s");
      send_eval(1, 1, xs, ws, 64'd0, 2'd3, "t3w");
      chk("t3w_const_y", out_y[1], 64'd0);
      chk("t3w_const_sat", {63'd0, out_sat[1]}, 64'd0);
      release_out(1, "t3w");
      send_eval(1, 1, xs, ws, 64'd0, 2'd2, "t3wt");
      chk("t3wt_const_y", out_y[1], NONE64);
      release_out(1, "t3wt");

      // Back-pressure on the output while beats are offered
      xs[0] = 64'h1_8000_0000; ws[0] = 64'h2_0000_0000;
      send_eval(0, 1, xs, ws, 64'd0, 2'd3, "t4");
      y0 = out_y[0];
      in_x[0] = ONE64; in_w[0] = ONE64; in_last[0] = 1'b1; in_valid[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t4_hold_y", out_y[0], y0);
         chk("t4_hold_ready", {63'd0, in_ready[0]}, 64'd0);
         chk("t4_hold_valid", {63'd0, out_valid[0]}, 64'd1);
      end
      out_ready[0] = 1'b1;
      tick();
      in_valid[0] = 1'b0; in_last[0] = 1'b0; out_ready[0] = 1'b0;
      chk("t4_rel_valid", {63'd0, out_valid[0]}, 64'd0);
      chk("t4_rel_ready", {63'd0, in_ready[0]}, 64'd1);
      xs[0] = 64'h0_4000_0000; ws[0] = ONE64;
      send_eval(0, 1, xs, ws, 64'd0, 2'd3, "t4_next");
      chk("t4_next_const", out_y[0], 64'h0_4000_0000);
      release_out(0, "t4_next");

      // Forced terminate at MAX_BEATS=4
      for (int i = 0; i < 8; i++) begin
         xs[i] = 64'h0_8000_0000 + 64'(i) * ONE64; ws[i] = ONE64;
      end
      ref_eval(4, xs, ws, 64'd0, 2'd3, 1'b1, ey, es);
      bias[2] = '0; act_sel[2] = 2'd3; in_last[2] = 1'b0; in_valid[2] = 1'b1;
      acc_n = 0;
      for (int i = 0; i < 6; i++) begin
         bit r;
         in_x[2] = xs[acc_n]; in_w[2] = ws[acc_n];
         r = in_ready[2];
         tick();
         if (r) acc_n++;
         if (i == 4) chk("t5_ready_5th", {63'd0, in_ready[2]}, 64'd0);
      end
      in_valid[2] = 1'b0;
      chk("t5_accepted", 64'(acc_n), 64'd4);
      wait_out(2);
      chk("t5_err", {63'd0, out_err[2]}, 64'd1);
      chk("t5_y", out_y[2], ey);
      release_out(2, "t5");
      send_eval(2, 4, xs, ws, 64'd0, 2'd3, "t5_last4");
      release_out(2, "t5_last4");

      // Async reset mid-evaluation, with a saturating partial sum
      xs[0] = QMAX64; ws[0] = QMAX64;
      bias[0] = '0; act_sel[0] = 2'd3; in_last[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_x[0] = xs[0]; in_w[0] = ws[0]; in_valid[0] = 1'b1;
         wait_ready(0);
         tick();
      end
      in_valid[0] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_in_ready", {63'd0, in_ready[0]}, 64'd1);
      chk("t6_out_valid", {63'd0, out_valid[0]}, 64'd0);
      chk("t6_out_y", out_y[0], 64'd0);
      chk("t6_out_sat", {63'd0, out_sat[0]}, 64'd0);
      chk("t6_out_err", {63'd0, out_err[0]}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      xs[0] = ONE64; ws[0] = ONE64;
      send_eval(0, 1, xs, ws, 64'd0, 2'd0, "t6_new");
      chk("t6_new_const", out_y[0], ONE64);
      release_out(0, "t6_new");

      // Randomized evaluations across all instances
      for (int k = 0; k < 36; k++) begin
         d = k % 3;
         n = (d == 2) ? $urandom_range(1, 4) : $urandom_range(1, 6);
         for (int i = 0; i < 8; i++) begin xs[i] = rnd_val(); ws[i] = rnd_val(); end
         send_eval(d, n, xs, ws, rnd_val(), 2'($urandom_range(0, 3)), "rnd");
         release_out(d, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
